// File: rtl/wb_arb_2m.sv
// Two-master Wishbone arbiter for the LED-matrix slave: round-robin grant,
// combinational pass-through while granted, stalled-strobe timeout abort.
module wb_arb_2m #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  state_o
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  logic [1:0]  state, state_nxt;
  logic        pri;
  logic [7:0]  cnt;
  logic        own0, own1, busy, tmo;
  logic        m_cyc, m_stb, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_data;

  assign own0 = (state == GNT0);
  assign own1 = (state == GNT1);
  assign busy = own0 | own1;

  assign m_cyc  = own1 ? m1_cyc_i  : m0_cyc_i;
  assign m_stb  = own1 ? m1_stb_i  : m0_stb_i;
  assign m_we   = own1 ? m1_we_i   : m0_we_i;
  assign m_sel  = own1 ? m1_sel_i  : m0_sel_i;
  assign m_addr = own1 ? m1_addr_i : m0_addr_i;
  assign m_data = own1 ? m1_data_i : m0_data_i;

  // A late ack on the final cycle still wins over the abort.
  assign tmo = busy & m_stb & ~s_ack_i & (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = pri ? GNT1 : GNT0;
        else if (m0_cyc_i)        state_nxt = GNT0;
        else if (m1_cyc_i)        state_nxt = GNT1;
      end
      GNT0, GNT1: state_nxt = (m_cyc && !tmo) ? state : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      pri   <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE) pri <= (state_nxt == GNT0);
      if (busy && state_nxt == state && m_stb && !s_ack_i) cnt <= cnt + 8'd1;
      else                                                  cnt <= 8'd0;
    end
  end

  assign s_cyc_o  = busy & m_cyc & ~tmo;
  assign s_stb_o  = busy & m_stb & ~tmo;
  assign s_we_o   = busy & m_we;
  assign s_sel_o  = busy ? m_sel  : 4'd0;
  assign s_addr_o = busy ? m_addr : 32'd0;
  assign s_data_o = busy ? m_data : 32'd0;

  // Responses are suppressed while reset is asserted so an aborted grant ends silently.
  assign m0_ack_o  = own0 & s_ack_i & ~rst_i;
  assign m1_ack_o  = own1 & s_ack_i & ~rst_i;
  assign m0_err_o  = own0 & tmo & ~rst_i;
  assign m1_err_o  = own1 & tmo & ~rst_i;
  assign m0_data_o = own0 ? s_data_i : 32'd0;
  assign m1_data_o = own1 ? s_data_i : 32'd0;

  assign gnt_o   = {own1, own0};
  assign state_o = state;
endmodule
